minn_preamble_gen: RTL and testbench
====================================

# minn_preamble_gen

Transmit-side counterpart of the Minn correlator antenna path. It stores one quarter-length complex training sequence A and streams the Minn preamble [A, A, −A, −A] on a valid/ready interface, optionally repeated back-to-back. The receive chain's quarter-lag correlation and energy windows are dimensioned against this block's output. It sits ahead of the DAC/upsampling chain and is kicked by the framing controller.

## Interface
- INPUT_WIDTH, 12, sample width of I and Q (two's complement)
- QUARTER_LEN, 512, samples per quarter; must be ≥ 2
- REP_WIDTH, 4, width of the repetition count
- ADDR_WIDTH, $clog2(QUARTER_LEN), derived; do not override

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  sequence write strobe
- cfg_addr  in  ADDR_WIDTH  sequence write index (0..QUARTER_LEN−1)
- cfg_i, cfg_q  in  INPUT_WIDTH  sequence sample
- start  in  1  begin preamble; accepted only when busy=0
- num_reps  in  REP_WIDTH  preamble repetitions, latched on start; 0 treated as 1
- abort  in  1  terminate the stream immediately
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_i, out_q  out  INPUT_WIDTH  signed preamble sample
- out_quarter  out  2  quarter index 0..3 of the current beat
- out_last  out  1  final beat of the final repetition
- busy  out  1  high from start acceptance until done/abort
- done  out  1  single-cycle pulse after the last beat is accepted

## Operation
- FSM states: IDLE, STREAM, DRAIN.
  - IDLE → STREAM on start: latch num_reps, clear counters.
  - STREAM issues RAM reads for index 0..QUARTER_LEN−1 over quarters 0..3, for each repetition.
  - STREAM → DRAIN after the final read is issued.
  - DRAIN → IDLE when the last beat is accepted; pulse done.
- Pipeline is two stages: a synchronous RAM read, then a sign/output register. Global advance = !out_valid || out_ready. The RAM read enable and both stage loads are qualified by advance.
- Sign: quarters 0 and 1 pass A unchanged; quarters 2 and 3 negate it. Negation saturates: −(−2^(W−1)) → 2^(W−1)−1, independently on I and Q.
- out_quarter, out_last and the sign travel with the data through both stages.
- cfg_we is honoured only when busy=0; writes while busy are dropped. RAM contents are not reset.
- start while busy is ignored.
- abort (any state): next edge clears both stage valids, out_valid=0, busy=0, returns to IDLE, no done pulse. abort has priority over start in the same cycle.
- Counter wrap: index wraps QUARTER_LEN−1 → 0 and increments quarter. Quarter wraps 3 → 0 and increments the repetition count.

## Timing
- Reset values: out_valid=0, out_i=0, out_q=0, out_quarter=0, out_last=0, busy=0, done=0. FSM is in IDLE, all counters are 0.
- busy rises on the edge that accepts start.
- First out_valid is 2 cycles after the start-accept edge when out_ready=1.
- With out_ready held at 1, the block emits 4·QUARTER_LEN·max(num_reps,1) consecutive beats with no bubbles, including across quarter and repetition boundaries.
- Stall: while out_valid=1 && out_ready=0, out_* hold stable and no read address advances.
- done pulses on the edge after the out_last beat handshake; busy falls on that same edge.
- A new start is accepted in the cycle done is high at the earliest.
- Reset mid-stream: immediate return to reset values; sequence RAM retains its contents.

## Structure
- Shared package minn_pkg:
  - quarter sign pattern constant (+, +, −, −)
  - saturating-negate function parameterised on width
  - quarter-index typedef (2-bit)
- Sub-module minn_preamble_ram: single-port write, single-port synchronous read with read enable, 2·INPUT_WIDTH wide, QUARTER_LEN deep. Output holds when read enable is low.

## Test plan
- QUARTER_LEN=4, load A=(1,−1),(2,3),(−2048,2047),(0,5), num_reps=1, ready=1 → 16 beats: A, A, then (−1,1),(−2,−3),(2047,−2047),(0,−5) twice. out_quarter steps 0,1,2,3. out_last on beat 16. done one cycle later. First valid 2 cycles after start.
- Same config with out_ready toggled pseudo-randomly → identical beat sequence, and outputs stable while stalled.
- num_reps=3 vs 0 → 48 contiguous beats with out_last only on beat 48; num_reps=0 yields 16 beats.
- abort asserted on beat 6 → out_valid=0 next cycle, busy=0, no done. A following start replays from index 0, quarter 0.
- cfg_we and start during busy → ignored: the stream is unchanged, and the next run shows the original RAM contents.
- rst_n asserted mid-stream → all outputs at reset values asynchronously. Restart without reloading reproduces the loaded sequence.

Source files
------------

// File: rtl/minn_pkg.sv
// Shared types and helpers for the Minn preamble generator.
// Quarter sign pattern is (+, +, -, -); negation saturates at the most negative code.
package minn_pkg;

  typedef logic [1:0] quarter_t;

  // Bit q set means quarter q carries -A.
  localparam logic [3:0] QUARTER_NEG = 4'b1100;

  localparam int MAX_W = 32;

  // Two's-complement negate of the low w bits of x, clamping -2^(w-1) to 2^(w-1)-1.
  function automatic logic [MAX_W-1:0] sat_neg(input logic [MAX_W-1:0] x, input int unsigned w);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] min_v;
    mask  = (MAX_W'(1) << w) - MAX_W'(1);
    min_v = MAX_W'(1) << (w - 1);
    if ((x & mask) == min_v) begin
      return min_v - MAX_W'(1);
    end
    return (~x + MAX_W'(1)) & mask;
  endfunction

endpackage

// File: rtl/minn_preamble_gen_if.sv
// Control, sequence-load and output-stream bundle of the Minn preamble generator.
// slave = generator side, master = framing controller / downstream side.
interface minn_preamble_gen_if #(
  parameter int INPUT_WIDTH = 12,
  parameter int QUARTER_LEN = 512,
  parameter int REP_WIDTH   = 4,
  parameter int ADDR_WIDTH  = $clog2(QUARTER_LEN)
);
  logic                   cfg_we;
  logic [ADDR_WIDTH-1:0]  cfg_addr;
  logic [INPUT_WIDTH-1:0] cfg_i;
  logic [INPUT_WIDTH-1:0] cfg_q;
  logic                   start;
  logic [REP_WIDTH-1:0]   num_reps;
  logic                   abort;
  logic                   out_valid;
  logic                   out_ready;
  logic [INPUT_WIDTH-1:0] out_i;
  logic [INPUT_WIDTH-1:0] out_q;
  minn_pkg::quarter_t     out_quarter;
  logic                   out_last;
  logic                   busy;
  logic                   done;

  modport master (
    output cfg_we, cfg_addr, cfg_i, cfg_q, start, num_reps, abort, out_ready,
    input  out_valid, out_i, out_q, out_quarter, out_last, busy, done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_i, cfg_q, start, num_reps, abort, out_ready,
    output out_valid, out_i, out_q, out_quarter, out_last, busy, done
  );
endinterface

// File: rtl/minn_preamble_ram.sv
// Quarter-sequence store: one write port, one synchronous read port with enable.
// Read data appears one cycle after re; it holds while re is low (the output-stage stall relies on this).
module minn_preamble_ram #(
  parameter int WIDTH      = 24,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdat,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdat
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdat_q;
  logic [WIDTH-1:0] rdat_d;

  always_comb begin
    rdat_d = rdat_q;
    if (re) begin
      rdat_d = mem[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdat;
    end
    rdat_q <= rdat_d;
  end

  assign rdat = rdat_q;
endmodule

// File: rtl/minn_preamble_gen.sv
// Streams the Minn preamble [A, A, -A, -A] x num_reps from a stored quarter sequence A.
// Two-stage pipe (RAM read, sign/output register); first beat 2 cycles after start; stalls freeze the whole pipe.
module minn_preamble_gen
  import minn_pkg::*;
#(
  parameter int INPUT_WIDTH = 12,
  parameter int QUARTER_LEN = 512,
  parameter int REP_WIDTH   = 4,
  parameter int ADDR_WIDTH  = $clog2(QUARTER_LEN)
) (
  input logic                clk,
  input logic                rst_n,
  minn_preamble_gen_if.slave bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] IDX_LAST = ADDR_WIDTH'(QUARTER_LEN - 1);

  logic [1:0]             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
  quarter_t               qtr_q, qtr_d;
  logic [REP_WIDTH-1:0]   rep_q, rep_d;
  logic [REP_WIDTH-1:0]   reps_q, reps_d;

  logic                   s1_vld_q, s1_vld_d;
  quarter_t               s1_qtr_q, s1_qtr_d;
  logic                   s1_neg_q, s1_neg_d;
  logic                   s1_last_q, s1_last_d;

  logic                   out_valid_q, out_valid_d;
  logic [INPUT_WIDTH-1:0] out_i_q, out_i_d;
  logic [INPUT_WIDTH-1:0] out_q_q, out_q_d;
  quarter_t               out_qtr_q, out_qtr_d;
  logic                   out_last_q, out_last_d;
  logic                   done_q, done_d;

  logic                     advance;
  logic                     issue;
  logic                     final_rd;
  logic                     ram_we;
  logic [2*INPUT_WIDTH-1:0] ram_dat;
  logic [INPUT_WIDTH-1:0]   ram_i, ram_q;
  logic [INPUT_WIDTH-1:0]   neg_i, neg_q;

  assign advance  = !out_valid_q || bus.out_ready;
  assign issue    = (state_q == S_STREAM) && advance;
  assign final_rd = (idx_q == IDX_LAST) && (qtr_q == 2'd3) && (rep_q == reps_q - REP_WIDTH'(1));
  assign ram_we   = bus.cfg_we && (state_q == S_IDLE);

  minn_preamble_ram #(
    .WIDTH      (2 * INPUT_WIDTH),
    .DEPTH      (QUARTER_LEN),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (bus.cfg_addr),
    .wdat  ({bus.cfg_i, bus.cfg_q}),
    .re    (issue),
    .raddr (idx_q),
    .rdat  (ram_dat)
  );

  assign ram_i = ram_dat[2*INPUT_WIDTH-1:INPUT_WIDTH];
  assign ram_q = ram_dat[INPUT_WIDTH-1:0];
  assign neg_i = INPUT_WIDTH'(sat_neg(MAX_W'(ram_i), INPUT_WIDTH));
  assign neg_q = INPUT_WIDTH'(sat_neg(MAX_W'(ram_q), INPUT_WIDTH));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    qtr_d       = qtr_q;
    rep_d       = rep_q;
    reps_d      = reps_q;
    s1_vld_d    = s1_vld_q;
    s1_qtr_d    = s1_qtr_q;
    s1_neg_d    = s1_neg_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    out_i_d     = out_i_q;
    out_q_d     = out_q_q;
    out_qtr_d   = out_qtr_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;

    if (bus.abort) begin
      state_d     = S_IDLE;
      s1_vld_d    = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = S_STREAM;
            reps_d  = (bus.num_reps == '0) ? REP_WIDTH'(1) : bus.num_reps;
            idx_d   = '0;
            qtr_d   = '0;
            rep_d   = '0;
          end
        end
        S_STREAM: begin
          if (issue) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + ADDR_WIDTH'(1);
            if (idx_q == IDX_LAST) begin
              qtr_d = qtr_q + 2'd1;
              if (qtr_q == 2'd3) begin
                rep_d = rep_q + REP_WIDTH'(1);
              end
            end
            if (final_rd) begin
              state_d = S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (out_valid_q && bus.out_ready && out_last_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // Stage tags are captured alongside the read so sign/last stay aligned with RAM data.
      if (advance) begin
        s1_vld_d    = issue;
        s1_qtr_d    = qtr_q;
        s1_neg_d    = QUARTER_NEG[qtr_q];
        s1_last_d   = final_rd;
        out_valid_d = s1_vld_q;
        if (s1_vld_q) begin
          out_i_d    = s1_neg_q ? neg_i : ram_i;
          out_q_d    = s1_neg_q ? neg_q : ram_q;
          out_qtr_d  = s1_qtr_q;
          out_last_d = s1_last_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      qtr_q       <= '0;
      rep_q       <= '0;
      reps_q      <= '0;
      s1_vld_q    <= 1'b0;
      s1_qtr_q    <= '0;
      s1_neg_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      out_qtr_q   <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      qtr_q       <= qtr_d;
      rep_q       <= rep_d;
      reps_q      <= reps_d;
      s1_vld_q    <= s1_vld_d;
      s1_qtr_q    <= s1_qtr_d;
      s1_neg_q    <= s1_neg_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
      out_qtr_q   <= out_qtr_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_i       = out_i_q;
  assign bus.out_q       = out_q_q;
  assign bus.out_quarter = out_qtr_q;
  assign bus.out_last    = out_last_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
endmodule

// File: tb/tb_minn_preamble_gen.sv
// Bench for minn_preamble_gen with QUARTER_LEN=4: scenario tasks checked against a
// loop-built model of the [A, A, -A, -A] x reps sequence.
module tb_minn_preamble_gen;
  localparam int W  = 12;
  localparam int QL = 4;
  localparam int RW = 4;
  localparam int AW = $clog2(QL);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  minn_preamble_gen_if #(.INPUT_WIDTH(W), .QUARTER_LEN(QL), .REP_WIDTH(RW)) bus ();

  minn_preamble_gen #(.INPUT_WIDTH(W), .QUARTER_LEN(QL), .REP_WIDTH(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  int a_i [QL];
  int a_q [QL];
  int exp_i[$], exp_q[$], exp_qtr[$];
  int got_i[$], got_q[$], got_qtr[$], got_last[$], got_cyc[$];
  int first_vld, done_cyc, done_cnt, stall_bad, bubbles, start_cyc;
  bit timed_out, busy_at_done, ab_vld, ab_busy;

  function automatic int sneg(int v);
    return (v == -(1 << (W - 1))) ? (1 << (W - 1)) - 1 : -v;
  endfunction

  function automatic void build_expect(int reps);
    int n = (reps == 0) ? 1 : reps;
    exp_i.delete(); exp_q.delete(); exp_qtr.delete();
    for (int r = 0; r < n; r++)
      for (int q = 0; q < 4; q++)
        for (int k = 0; k < QL; k++) begin
          exp_i.push_back(q >= 2 ? sneg(a_i[k]) : a_i[k]);
          exp_q.push_back(q >= 2 ? sneg(a_q[k]) : a_q[k]);
          exp_qtr.push_back(q);
        end
  endfunction

  task automatic load_seq();
    for (int k = 0; k < QL; k++) begin
      @(negedge clk);
      bus.cfg_we = 1'b1; bus.cfg_addr = AW'(k); bus.cfg_i = W'(a_i[k]); bus.cfg_q = W'(a_q[k]);
    end
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic kick(input int reps);
    @(negedge clk);
    bus.start = 1'b1; bus.num_reps = RW'(reps);
    @(negedge clk);
    bus.start = 1'b0; start_cyc = cyc;
  endtask

  // Records accepted beats and timing facts; the scenario tasks judge them.
  task automatic collect(input bit rnd, input int abort_beat);
    bit prev_stall = 1'b0;
    bit seen_last = 1'b0;
    int after = 0;
    logic [W-1:0] pv_i = '0, pv_q = '0;
    logic [1:0] pv_qt = '0;
    logic pv_l = 1'b0;
    got_i.delete(); got_q.delete(); got_qtr.delete(); got_last.delete(); got_cyc.delete();
    first_vld = -1; done_cyc = -1; done_cnt = 0; stall_bad = 0; bubbles = 0;
    timed_out = 1'b1; busy_at_done = 1'b1; ab_vld = 1'b1; ab_busy = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = bus.busy; end
      end
      if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_i !== pv_i || bus.out_q !== pv_q ||
                         bus.out_quarter !== pv_qt || bus.out_last !== pv_l)) stall_bad++;
      if (seen_last) begin
        bus.out_ready = 1'b1;
        after++;
        if (after >= 4) begin timed_out = 1'b0; break; end
      end else begin
        bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.out_valid && first_vld < 0) first_vld = cyc;
        if (first_vld >= 0 && !bus.out_valid) bubbles++;
        if (bus.out_valid && bus.out_ready) begin
          got_i.push_back($signed(bus.out_i));
          got_q.push_back($signed(bus.out_q));
          got_qtr.push_back(int'(bus.out_quarter));
          got_last.push_back(int'(bus.out_last));
          got_cyc.push_back(cyc);
          if (bus.out_last) seen_last = 1'b1;
          if (got_i.size() == abort_beat) begin
            bus.abort = 1'b1;
            @(negedge clk);
            bus.abort = 1'b0;
            ab_vld = bus.out_valid; ab_busy = bus.busy;
            if (bus.done) done_cnt++;
            repeat (4) begin @(negedge clk); if (bus.done) done_cnt++; end
            timed_out = 1'b0;
            break;
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        pv_i = bus.out_i; pv_q = bus.out_q; pv_qt = bus.out_quarter; pv_l = bus.out_last;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({bus.out_valid, bus.out_i, bus.out_q, bus.out_quarter, bus.out_last, bus.busy, bus.done} !== '0)
      begin bad++; $display("FAIL reset_values got v=%0b i=%0d q=%0d qt=%0d l=%0b busy=%0b done=%0b want all 0",
        bus.out_valid, bus.out_i, bus.out_q, bus.out_quarter, bus.out_last, bus.busy, bus.done); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    a_i = '{1, 2, -2048, 0};
    a_q = '{-1, 3, 2047, 5};
    load_seq();
    build_expect(1);
    kick(1);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL basic_busy_rise got=%0b want=1", bus.busy); end
    collect(1'b0, -1);
    total++; if (timed_out) begin bad++; $display("FAIL basic_timeout got=timeout want=complete"); end
    total++; if (got_i.size() != 16) begin bad++; $display("FAIL basic_count got=%0d want=16", got_i.size()); end
    for (int k = 0; k < got_i.size() && k < exp_i.size(); k++) begin
      total++;
      if (got_i[k] !== exp_i[k] || got_q[k] !== exp_q[k] || got_qtr[k] !== exp_qtr[k] || got_last[k] !== int'(k == exp_i.size() - 1))
        begin bad++; $display("FAIL basic_beat%0d got=(%0d,%0d,q%0d,l%0d) want=(%0d,%0d,q%0d,l%0d)", k, got_i[k], got_q[k],
          got_qtr[k], got_last[k], exp_i[k], exp_q[k], exp_qtr[k], int'(k == exp_i.size() - 1)); end
    end
    if (got_i.size() > 10) begin
      total++;
      if (got_i[10] !== 2047 || got_q[10] !== -2047)
        begin bad++; $display("FAIL basic_satneg got=(%0d,%0d) want=(2047,-2047)", got_i[10], got_q[10]); end
    end
    total++; if (first_vld != start_cyc + 2) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", first_vld - start_cyc, 2); end
    total++; if (bubbles != 0) begin bad++; $display("FAIL basic_bubbles got=%0d want=0", bubbles); end
    if (got_cyc.size() > 0) begin
      total++;
      if (done_cyc != got_cyc[got_cyc.size() - 1] + 1)
        begin bad++; $display("FAIL basic_done_time got=%0d want=%0d", done_cyc, got_cyc[got_cyc.size() - 1] + 1); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done_pulses got=%0d want=1", done_cnt); end
    total++; if (busy_at_done !== 1'b0) begin bad++; $display("FAIL basic_busy_fall got=%0b want=0", busy_at_done); end
  endtask

  task automatic test_backpressure();
    build_expect(1);
    kick(1);
    collect(1'b1, -1);
    total++; if (timed_out || got_i.size() != 16) begin bad++; $display("FAIL bp_count got=%0d want=16", got_i.size()); end
    for (int k = 0; k < got_i.size() && k < exp_i.size(); k++) begin
      total++;
      if (got_i[k] !== exp_i[k] || got_q[k] !== exp_q[k] || got_qtr[k] !== exp_qtr[k] || got_last[k] !== int'(k == exp_i.size() - 1))
        begin bad++; $display("FAIL bp_beat%0d got=(%0d,%0d,q%0d,l%0d) want=(%0d,%0d,q%0d)", k, got_i[k], got_q[k],
          got_qtr[k], got_last[k], exp_i[k], exp_q[k], exp_qtr[k]); end
    end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_stall_stable got=%0d changes want=0", stall_bad); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL bp_done_pulses got=%0d want=1", done_cnt); end
  endtask

  task automatic test_reps();
    for (int k = 0; k < QL; k++) begin
      a_i[k] = $urandom_range(0, 4095) - 2048;
      a_q[k] = $urandom_range(0, 4095) - 2048;
    end
    a_i[1] = -2048;
    load_seq();
    for (int t = 0; t < 2; t++) begin
      int reps = (t == 0) ? 3 : 0;
      build_expect(reps);
      kick(reps);
      collect(1'b0, -1);
      total++;
      if (timed_out || got_i.size() != exp_i.size())
        begin bad++; $display("FAIL reps%0d_count got=%0d want=%0d", reps, got_i.size(), exp_i.size()); end
      for (int k = 0; k < got_i.size() && k < exp_i.size(); k++) begin
        total++;
        if (got_i[k] !== exp_i[k] || got_q[k] !== exp_q[k] || got_qtr[k] !== exp_qtr[k] || got_last[k] !== int'(k == exp_i.size() - 1))
          begin bad++; $display("FAIL reps%0d_beat%0d got=(%0d,%0d,q%0d,l%0d) want=(%0d,%0d,q%0d)", reps, k, got_i[k], got_q[k],
            got_qtr[k], got_last[k], exp_i[k], exp_q[k], exp_qtr[k]); end
      end
      total++; if (bubbles != 0) begin bad++; $display("FAIL reps%0d_bubbles got=%0d want=0", reps, bubbles); end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL reps%0d_done got=%0d want=1", reps, done_cnt); end
    end
  endtask

  task automatic test_abort();
    build_expect(1);
    kick(1);
    collect(1'b0, 6);
    total++; if (got_i.size() != 6) begin bad++; $display("FAIL abort_beats got=%0d want=6", got_i.size()); end
    total++; if (ab_vld !== 1'b0) begin bad++; $display("FAIL abort_valid got=%0b want=0", ab_vld); end
    total++; if (ab_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b want=0", ab_busy); end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", done_cnt); end
    kick(1);
    collect(1'b0, -1);
    total++; if (timed_out || got_i.size() != 16) begin bad++; $display("FAIL abort_replay_count got=%0d want=16", got_i.size()); end
    for (int k = 0; k < got_i.size() && k < exp_i.size(); k++) begin
      total++;
      if (got_i[k] !== exp_i[k] || got_q[k] !== exp_q[k] || got_qtr[k] !== exp_qtr[k])
        begin bad++; $display("FAIL abort_replay_beat%0d got=(%0d,%0d,q%0d) want=(%0d,%0d,q%0d)", k, got_i[k], got_q[k],
          got_qtr[k], exp_i[k], exp_q[k], exp_qtr[k]); end
    end
  endtask

  task automatic test_busy_ignore();
    build_expect(1);
    kick(1);
    fork
      collect(1'b1, -1);
      begin
        repeat (5) @(negedge clk);
        bus.cfg_we = 1'b1; bus.cfg_addr = '0; bus.cfg_i = W'(7); bus.cfg_q = W'(-7);
        bus.start = 1'b1; bus.num_reps = RW'(5);
        repeat (3) @(negedge clk);
        bus.cfg_we = 1'b0; bus.start = 1'b0;
      end
    join
    for (int t = 0; t < 2; t++) begin
      if (t == 1) begin kick(1); collect(1'b0, -1); end
      total++;
      if (timed_out || got_i.size() != 16 || done_cnt != 1)
        begin bad++; $display("FAIL busy_ignore%0d_count got=%0d beats %0d done want=16 beats 1 done", t, got_i.size(), done_cnt); end
      for (int k = 0; k < got_i.size() && k < exp_i.size(); k++) begin
        total++;
        if (got_i[k] !== exp_i[k] || got_q[k] !== exp_q[k])
          begin bad++; $display("FAIL busy_ignore%0d_beat%0d got=(%0d,%0d) want=(%0d,%0d)", t, k, got_i[k], got_q[k], exp_i[k], exp_q[k]); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    bit pre_vld;
    kick(2);
    bus.out_ready = 1'b1;
    repeat (8) @(negedge clk);
    pre_vld = bus.out_valid;
    #2 rst_n = 1'b0;
    #1;
    total++; if (pre_vld !== 1'b1) begin bad++; $display("FAIL rstmid_pre_valid got=%0b want=1", pre_vld); end
    total++;
    if ({bus.out_valid, bus.out_i, bus.out_q, bus.out_quarter, bus.out_last, bus.busy, bus.done} !== '0)
      begin bad++; $display("FAIL rstmid_async got v=%0b i=%0d q=%0d qt=%0d l=%0b busy=%0b want all 0",
        bus.out_valid, bus.out_i, bus.out_q, bus.out_quarter, bus.out_last, bus.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    build_expect(1);
    kick(1);
    collect(1'b0, -1);
    total++; if (timed_out || got_i.size() != 16) begin bad++; $display("FAIL rstmid_count got=%0d want=16", got_i.size()); end
    for (int k = 0; k < got_i.size() && k < exp_i.size(); k++) begin
      total++;
      if (got_i[k] !== exp_i[k] || got_q[k] !== exp_q[k] || got_qtr[k] !== exp_qtr[k])
        begin bad++; $display("FAIL rstmid_beat%0d got=(%0d,%0d,q%0d) want=(%0d,%0d,q%0d)", k, got_i[k], got_q[k],
          got_qtr[k], exp_i[k], exp_q[k], exp_qtr[k]); end
    end
  endtask

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_i = '0; bus.cfg_q = '0;
    bus.start = 1'b0; bus.num_reps = '0; bus.abort = 1'b0; bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_reps();
    test_abort();
    test_busy_ignore();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
